// File: rtl/glitch_pulse_gen.sv
// Trigger-driven glitch pulse train generator: delay, then num pulses of width with spacing.
// Trigger latency SYNC_STAGES cycles to acceptance; outputs registered from next state.
module glitch_pulse_gen #(
  parameter int SYNC_STAGES = 2,
  parameter bit GLITCH_POL  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger_i,
  input  logic        arm_i,
  input  logic [15:0] delay_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  num_pulses_i,
  input  logic [15:0] pulse_spacing_i,
  output logic        glitch_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {IDLE, DELAY, PULSE, SPACE, DONE} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic        prev_q, prev_d;
  logic        trig_edge;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] spacing_q, spacing_d;
  logic [7:0]  width_q, width_d;
  logic [7:0]  pulses_q, pulses_d;
  logic        glitch_q, glitch_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], trigger_i};
    prev_d    = sync_q[SYNC_STAGES-1];
    trig_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    spacing_d = spacing_q;
    width_d   = width_q;
    pulses_d  = pulses_q;

    // Each timed state loads cnt with (cycles-1) and leaves when it reaches zero.
    case (state_q)
      IDLE: begin
        if (arm_i && trig_edge) begin
          width_d   = width_i;
          pulses_d  = num_pulses_i;
          spacing_d = pulse_spacing_i;
          if (width_i == 8'd0 || num_pulses_i == 8'd0) begin
            state_d = DONE;
          end else if (delay_i == 16'd0) begin
            state_d = PULSE;
            cnt_d   = {8'd0, width_i - 8'd1};
          end else begin
            state_d = DELAY;
            cnt_d   = delay_i - 16'd1;
          end
        end
      end
      DELAY: begin
        if (cnt_q == 16'd0) begin
          state_d = PULSE;
          cnt_d   = {8'd0, width_q - 8'd1};
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      PULSE: begin
        if (cnt_q == 16'd0) begin
          pulses_d = pulses_q - 8'd1;
          if (pulses_q == 8'd1) begin
            state_d = DONE;
          end else begin
            state_d = SPACE;
            cnt_d   = (spacing_q == 16'd0) ? 16'd0 : spacing_q - 16'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      SPACE: begin
        if (cnt_q == 16'd0) begin
          state_d = PULSE;
          cnt_d   = {8'd0, width_q - 8'd1};
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Disarm aborts any sequence in flight without a done strobe.
    if (state_q != IDLE && !arm_i) begin
      state_d = IDLE;
    end

    glitch_d = (state_d == PULSE) ? GLITCH_POL : ~GLITCH_POL;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= 16'd0;
      spacing_q <= 16'd0;
      width_q   <= 8'd0;
      pulses_q  <= 8'd0;
      glitch_q  <= ~GLITCH_POL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      spacing_q <= spacing_d;
      width_q   <= width_d;
      pulses_q  <= pulses_d;
      glitch_q  <= glitch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign glitch_o = glitch_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Scoreboard bench for glitch_pulse_gen: stimulus pushes expected rise/fall/done events.
module tb_glitch_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger_i = 1'b0;
  logic        arm_i = 1'b0;
  logic [15:0] delay_i = '0;
  logic [7:0]  width_i = '0;
  logic [7:0]  num_pulses_i = '0;
  logic [15:0] pulse_spacing_i = '0;
  logic        glitch_o, busy_o, done_o;

  glitch_pulse_gen #(.SYNC_STAGES(2), .GLITCH_POL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .trigger_i(trigger_i), .arm_i(arm_i),
    .delay_i(delay_i), .width_i(width_i), .num_pulses_i(num_pulses_i),
    .pulse_spacing_i(pulse_spacing_i),
    .glitch_o(glitch_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Event kinds: 0 = glitch rises, 1 = glitch falls, 2 = done strobe.
  typedef struct packed {
    logic [1:0] kind;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  fails = 0;
  logic prev_g = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: kind %0d at cyc %0d, none expected", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind[1:0] || e.cyc != cyc) begin
        fails++;
        $display("FAIL event_order: got kind %0d at cyc %0d, expected kind %0d at cyc %0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (glitch_o && !prev_g) check_ev(0);
    if (!glitch_o && prev_g) check_ev(1);
    if (done_o) check_ev(2);
    prev_g = glitch_o;
  end

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind[1:0];
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Expected timeline from the trigger sample edge s; acceptance edge is s+2.
  task automatic push_seq(input int s, input int d, input int w, input int n, input int sp);
    int e, gap, r;
    e   = s + 2;
    gap = (sp == 0) ? 1 : sp;
    if (w == 0 || n == 0) begin
      push(2, e);
    end else begin
      r = e;
      for (int k = 0; k < n; k++) begin
        r = e + d + k * (w + gap);
        push(0, r);
        push(1, r + w);
      end
      push(2, r + w);
    end
  endtask

  // Returns at the negedge following acceptance edge s+2.
  task automatic fire(input int d, input int w, input int n, input int sp, output int s);
    @(negedge clk);
    delay_i         = d[15:0];
    width_i         = w[7:0];
    num_pulses_i    = n[7:0];
    pulse_spacing_i = sp[15:0];
    trigger_i       = 1'b1;
    s = cyc + 1;
    repeat (3) @(negedge clk);
    trigger_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (busy_o && i < budget) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (busy_o) begin
      fails++;
      $display("FAIL idle_timeout: busy_o still %b after %0d cycles, expected 0", busy_o, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  int s;

  initial begin
    repeat (3) @(negedge clk);
    check_val("reset_glitch", glitch_o, 1'b0);
    check_val("reset_busy", busy_o, 1'b0);
    check_val("reset_done", done_o, 1'b0);
    rst_n = 1'b1;
    arm_i = 1'b1;
    repeat (2) @(negedge clk);

    // Single pulse after delay 10.
    fire(10, 3, 1, 0, s);
    push_seq(s, 10, 3, 1, 0);
    check_val("t1_busy_at_accept", busy_o, 1'b1);
    wait_idle(200);
    check_val("t1_done_low", done_o, 1'b0);

    // Zero delay train; inputs changed mid-sequence must not matter.
    fire(0, 2, 3, 4, s);
    push_seq(s, 0, 2, 3, 4);
    width_i = 8'd7; num_pulses_i = 8'd1; pulse_spacing_i = 16'd9;
    wait_idle(200);

    // Zero spacing gives a single inactive cycle.
    fire(5, 1, 2, 0, s);
    push_seq(s, 5, 1, 2, 0);
    wait_idle(200);

    // Degenerate width / count.
    fire(3, 0, 3, 2, s);
    push_seq(s, 3, 0, 3, 2);
    wait_idle(50);
    fire(3, 4, 0, 2, s);
    push_seq(s, 3, 4, 0, 2);
    wait_idle(50);

    // Terminal width value.
    fire(0, 255, 1, 0, s);
    push_seq(s, 0, 255, 1, 0);
    wait_idle(400);

    // Abort during first pulse of a five-pulse sequence.
    fire(0, 4, 5, 2, s);
    push(0, s + 2);
    @(negedge clk);
    arm_i = 1'b0;
    push(1, s + 4);
    wait_idle(20);
    check_val("t5_abort_glitch", glitch_o, 1'b0);

    // Trigger while disarmed is ignored.
    fire(0, 2, 1, 0, s);
    repeat (8) @(negedge clk);
    check_val("t5_disarmed_busy", busy_o, 1'b0);
    arm_i = 1'b1;
    repeat (2) @(negedge clk);

    // Retrigger while busy is ignored.
    fire(1, 2, 2, 3, s);
    push_seq(s, 1, 2, 2, 3);
    fire(0, 6, 4, 1, s);
    wait_idle(200);

    // Reset asserted mid-pulse clears output immediately.
    fire(0, 10, 1, 0, s);
    push(0, s + 2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_reset_glitch", glitch_o, 1'b0);
    check_val("t6_reset_busy", busy_o, 1'b0);
    push(1, cyc + 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("t6_post_reset_busy", busy_o, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_events: %0d expected events never seen, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
